sector_sequencer: RTL and testbench

// Timing and sequencing controller for the sector serializer.
// - Generates the free-running rotational sector timebase: sector_strobe, the sector

---
 rtl/sector_sequencer.sv | 155 +++++++++++++++
 tb/tb_sector_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sector_sequencer.sv
// Sector timing controller: rotational timebase, cylinder/head seek control and the
// prefetch-to-buffer fetch handshake feeding the sector serializer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_READY   | head settled on cyl; accepts seek commands, ready=1
// S_SEEK    | settle counter running toward the latched target, ready=0
// P_IDLE    | no buffer fetch outstanding
// P_REQ     | mem_req held with a frozen mem_addr until mem_ack is seen
module sector_sequencer #(
  parameter int SECTOR_CYCLES = 3900,
  parameter int SECTORS       = 12,
  parameter int MAX_CYL       = 405,
  parameter int SEEK_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  hs_in,
  input  logic        seek_strobe,
  input  logic [8:0]  seek_cyl,
  input  logic        prefetch,
  input  logic        mem_ack,
  output logic        sector_strobe,
  output logic        index_pulse,
  output logic [4:0]  sect,
  output logic [8:0]  cyl,
  output logic [1:0]  hs,
  output logic        ready,
  output logic        seek_err,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        overrun
);

  localparam int TICK_W   = $clog2(SECTOR_CYCLES);
  localparam int SECT_W   = $clog2(SECTORS);
  localparam int SETTLE_W = $clog2(SEEK_CYCLES);

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(SECTOR_CYCLES - 1);
  localparam logic [SECT_W-1:0]   SECT_LAST   = SECT_W'(SECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SEEK_CYCLES - 1);
  localparam logic [8:0]          CYL_MAX     = 9'(MAX_CYL);

  localparam logic [0:0] S_READY = 1'b0;
  localparam logic [0:0] S_SEEK  = 1'b1;
  localparam logic [0:0] P_IDLE  = 1'b0;
  localparam logic [0:0] P_REQ   = 1'b1;

  logic [TICK_W-1:0]   tick;
  logic [SECT_W-1:0]   sect_q;
  logic [0:0]          seek_state;
  logic [SETTLE_W-1:0] settle;
  logic [8:0]          target_cyl;
  logic [0:0]          pf_state;

  assign sect = 5'(sect_q);

  // Timebase: free-running, never stalled by seeks or fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick          <= '0;
      sect_q        <= SECT_LAST;
      hs            <= 2'd0;
      sector_strobe <= 1'b0;
      index_pulse   <= 1'b0;
    end else begin
      sector_strobe <= 1'b0;
      index_pulse   <= 1'b0;
      if (tick == TICK_LAST) begin
        tick          <= '0;
        sector_strobe <= 1'b1;
        hs            <= hs_in;
        if (sect_q == SECT_LAST) begin
          sect_q      <= '0;
          index_pulse <= 1'b1;
        end else begin
          sect_q <= sect_q + 1'b1;
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seek_state <= S_READY;
      settle     <= '0;
      target_cyl <= 9'd0;
      cyl        <= 9'd0;
      ready      <= 1'b1;
      seek_err   <= 1'b0;
    end else begin
      case (seek_state)
        S_READY: begin
          if (seek_strobe) begin
            if (seek_cyl > CYL_MAX) begin
              seek_err <= 1'b1;
            end else if (seek_cyl == cyl) begin
              seek_err <= 1'b0;
            end else begin
              seek_err   <= 1'b0;
              target_cyl <= seek_cyl;
              settle     <= SETTLE_LOAD;
              ready      <= 1'b0;
              seek_state <= S_SEEK;
            end
          end
        end
        S_SEEK: begin
          if (settle == '0) begin
            cyl        <= target_cyl;
            ready      <= 1'b1;
            seek_state <= S_READY;
          end else begin
            settle <= settle - 1'b1;
          end
        end
        default: seek_state <= S_READY;
      endcase
    end
  end

  // The fetch address is frozen at request time, so a seek starting under an
  // outstanding request cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_state <= P_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 16'd0;
      overrun  <= 1'b0;
    end else begin
      case (pf_state)
        P_IDLE: begin
          if (prefetch && ready) begin
            mem_req  <= 1'b1;
            mem_addr <= {hs, cyl, sect};
            pf_state <= P_REQ;
          end
        end
        P_REQ: begin
          if (prefetch) begin
            overrun <= 1'b1;
          end
          if (mem_ack) begin
            mem_req  <= 1'b0;
            pf_state <= P_IDLE;
          end
        end
        default: pf_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sector_sequencer.sv
// Directed bench for sector_sequencer: timebase, seeks, prefetch handshake,
// overrun/drop behaviour and asynchronous reset mid-operation.
module tb_sector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  hs_in;
  logic        seek_strobe;
  logic [8:0]  seek_cyl;
  logic        prefetch;
  logic        mem_ack;
  logic        sector_strobe;
  logic        index_pulse;
  logic [4:0]  sect;
  logic [8:0]  cyl;
  logic [1:0]  hs;
  logic        ready;
  logic        seek_err;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  logic req_prev = 1'b0;

  sector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .seek_strobe(seek_strobe),
    .seek_cyl(seek_cyl), .prefetch(prefetch), .mem_ack(mem_ack),
    .sector_strobe(sector_strobe), .index_pulse(index_pulse), .sect(sect),
    .cyl(cyl), .hs(hs), .ready(ready), .seek_err(seek_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && req_prev !== 1'b1) rises++;
    req_prev = mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_strobe"}, 32'(sector_strobe), 32'd0);
    chk({tag, "_index"}, 32'(index_pulse), 32'd0);
    chk({tag, "_sect"}, 32'(sect), 32'd11);
    chk({tag, "_cyl"}, 32'(cyl), 32'd0);
    chk({tag, "_hs"}, 32'(hs), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_seek_err"}, 32'(seek_err), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int k;
    int n;
    int stray;
    int r0;
    logic [8:0] prev_cyl;
    logic low_seen;

    rst_n = 1'b0; hs_in = 2'd2; seek_strobe = 1'b0; seek_cyl = 9'd0;
    prefetch = 1'b0; mem_ack = 1'b0;
    #22;
    check_reset_values("reset");

    // Timebase over 13 sector periods
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    stray = 0;
    for (int c = 1; c <= 13 * 3900; c++) begin
      @(posedge clk); #1;
      if (c == 3899) chk("pre_first_sect", 32'(sect), 32'd11);
      if (sector_strobe) begin
        k++;
        chk("strobe_cycle", c, k * 3900);
        chk("strobe_sect", 32'(sect), (k - 1) % 12);
        chk("strobe_index", 32'(index_pulse), 32'(k == 1 || k == 13));
        if (k == 1) chk("strobe_hs", 32'(hs), 32'd2);
      end
      if (index_pulse && !sector_strobe) stray++;
    end
    chk("strobe_count", k, 13);
    chk("stray_index", stray, 0);

    // Legal seek 0 -> 100
    seek_cyl = 9'd100; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("seek_ready_low", 32'(ready), 32'd0);
    chk("seek_err_legal", 32'(seek_err), 32'd0);
    n = 0;
    prev_cyl = cyl;
    while (ready !== 1'b1 && n < 2000) begin
      prev_cyl = cyl;
      step(1);
      n++;
    end
    chk("seek_low_cycles", n, 1000);
    chk("seek_cyl_before_rise", 32'(prev_cyl), 32'd0);
    chk("seek_cyl_after", 32'(cyl), 32'd100);

    // Illegal seek, then null seek
    seek_cyl = 9'd406; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("illegal_err", 32'(seek_err), 32'd1);
    chk("illegal_cyl", 32'(cyl), 32'd100);
    chk("illegal_ready", 32'(ready), 32'd1);
    seek_cyl = 9'd100; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("null_err_cleared", 32'(seek_err), 32'd0);
    low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready !== 1'b1) low_seen = 1'b1;
      step(1);
    end
    chk("null_ready_stays", 32'(low_seen), 32'd0);
    chk("null_cyl", 32'(cyl), 32'd100);

    // Prefetch handshake at sect 5, hs 2, cyl 100
    n = 0;
    while (!(sector_strobe && sect == 5'd5) && n < 30000) begin
      step(1);
      n++;
    end
    chk("reach_sect5", 32'(sect), 32'd5);
    r0 = rises;
    prefetch = 1'b1;
    step(1);
    prefetch = 1'b0;
    chk("hs_req_0", 32'(mem_req), 32'd1);
    chk("hs_addr_0", 32'(mem_addr), 32'h8C85);
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk("hs_req_hold", 32'(mem_req), 32'd1);
      chk("hs_addr_hold", 32'(mem_addr), 32'h8C85);
    end
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("hs_req_fall", 32'(mem_req), 32'd0);
    chk("hs_overrun_clear", 32'(overrun), 32'd0);
    step(2);
    chk("hs_one_request", rises, r0 + 1);

    // Overrun: second prefetch while request outstanding
    r0 = rises;
    prefetch = 1'b1;
    step(1);
    chk("ovr_req", 32'(mem_req), 32'd1);
    step(1);
    prefetch = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_req_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    step(3);
    chk("ovr_req_done", 32'(mem_req), 32'd0);
    chk("ovr_one_request", rises, r0 + 1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Prefetch dropped during a seek; seek_strobe ignored while seeking
    seek_cyl = 9'd200; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("seek2_ready_low", 32'(ready), 32'd0);
    seek_cyl = 9'd500; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("seek2_strobe_ignored", 32'(seek_err), 32'd0);
    r0 = rises;
    prefetch = 1'b1;
    step(1);
    prefetch = 1'b0;
    step(3);
    chk("drop_no_req", 32'(mem_req), 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      step(1);
      n++;
    end
    chk("seek2_ready", 32'(ready), 32'd1);
    chk("seek2_cyl", 32'(cyl), 32'd200);
    chk("drop_rises", rises, r0);

    // Async reset mid-seek with a request outstanding
    prefetch = 1'b1;
    step(1);
    prefetch = 1'b0;
    chk("rst_pre_req", 32'(mem_req), 32'd1);
    seek_cyl = 9'd300; seek_strobe = 1'b1;
    step(1);
    seek_strobe = 1'b0;
    chk("rst_pre_seek", 32'(ready), 32'd0);
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sector_strobe && n < 5000);
    chk("post_rst_strobe_cycle", n, 3900);
    chk("post_rst_sect", 32'(sect), 32'd0);
    chk("post_rst_index", 32'(index_pulse), 32'd1);
    chk("post_rst_hs", 32'(hs), 32'd2);
    chk("post_rst_cyl", 32'(cyl), 32'd0);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_req", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
